// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Brief    : Shared encodings and sizing for the DMEM port arbiter.
// Revision : 1.0
// ============================================================================
package dmem_arb_pkg;

    localparam logic [0:0] ARB_UNLOCKED   = 1'b0;
    localparam logic [0:0] ARB_LOCKED     = 1'b1;

    localparam int         MEM_RD_LATENCY = 1;
    localparam int         RESP_DEPTH     = 2;
    localparam int         RESP_CNT_W     = $clog2(RESP_DEPTH + 1);

endpackage
`default_nettype wire

// File: rtl/dmem_resp_skid.sv
`default_nettype none
// ============================================================================
// Module   : dmem_resp_skid
// Brief    : Two-entry read-response FIFO with occupancy output.
// Revision : 1.0
// ============================================================================
module dmem_resp_skid
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    input  logic                  ready,
    output logic [RESP_CNT_W-1:0] count
);

    logic [DATA_WIDTH-1:0] r_mem [RESP_DEPTH];
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [RESP_CNT_W-1:0] r_count;
    logic                  w_pop;

    assign valid = (r_count != '0);
    assign w_pop = valid & ready;
    assign data  = r_mem[r_rd_ptr];
    assign count = r_count;

    // Two entries, so each pointer is a single toggling bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RESP_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Brief    : Round-robin, burst-locking arbiter sharing one DMEM port.
// Revision : 1.0
// ============================================================================
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int PORTS      = 3,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int LOCK_BURST = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORTS-1:0]            req_valid,
    input  logic [PORTS-1:0]            req_we,
    input  logic [PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [PORTS*DATA_WIDTH-1:0] req_wdata,
    input  logic [PORTS*STRB_WIDTH-1:0] req_strb,
    input  logic [PORTS-1:0]            req_last,
    output logic [PORTS-1:0]            req_ready,
    output logic [PORTS-1:0]            resp_valid,
    output logic [PORTS*DATA_WIDTH-1:0] resp_data,
    input  logic [PORTS-1:0]            resp_ready,
    output logic                        mem_en,
    output logic                        mem_ren,
    output logic [STRB_WIDTH-1:0]       mem_wen,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0]       mem_wr_data,
    input  logic [DATA_WIDTH-1:0]       mem_rd_data
);

    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

    // Returns {found, index}; scanning offsets downward lets the smallest
    // offset from the start pointer overwrite any later candidate.
    function automatic logic [PW:0] rr_search(input logic [PORTS-1:0] elig,
                                              input logic [PW-1:0]    start);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            idx = (int'(start) + i) % PORTS;
            if (elig[idx]) begin
                res = {1'b1, PW'(idx)};
            end
        end
        return res;
    endfunction

    function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
        return (p == PW'(PORTS - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [PW-1:0]         r_lock_port;
    logic [PW-1:0]         w_lock_nxt;
    logic [PW-1:0]         r_rr_ptr;
    logic [PW-1:0]         w_rr_nxt;
    logic [PORTS-1:0]      r_inflight;
    logic [PORTS-1:0]      w_pop;
    logic [PORTS-1:0]      w_credit_ok;
    logic [PORTS-1:0]      w_eligible;
    logic [PORTS-1:0]      w_grant;
    logic [RESP_CNT_W-1:0] w_count [PORTS];
    logic [PW:0]           w_search;
    logic                  w_gnt_any;
    logic [PW-1:0]         w_gnt_idx;

    // A read may issue only if its response is sure to find a buffer slot.
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            w_credit_ok[p] = (int'(r_inflight[p]) + int'(w_count[p]) - int'(w_pop[p])) < RESP_DEPTH;
        end
    end

    assign w_eligible = req_valid & (req_we | w_credit_ok);
    assign w_search   = rr_search(w_eligible, r_rr_ptr);

    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_grant   = '0;
        if (r_state == ARB_LOCKED) begin
            w_gnt_any = w_eligible[r_lock_port];
            w_gnt_idx = r_lock_port;
        end else begin
            w_gnt_any = w_search[PW];
            w_gnt_idx = w_search[PW-1:0];
        end
        w_gnt_any = w_gnt_any & rst_n;
        if (w_gnt_any) begin
            w_grant[w_gnt_idx] = 1'b1;
        end
    end

    assign req_ready = w_grant;

    always_comb begin
        mem_en      = w_gnt_any;
        mem_ren     = 1'b0;
        mem_wen     = '0;
        mem_addr    = '0;
        mem_wr_data = '0;
        if (w_gnt_any) begin
            mem_ren     = ~req_we[w_gnt_idx];
            mem_wen     = req_we[w_gnt_idx] ? req_strb[int'(w_gnt_idx)*STRB_WIDTH +: STRB_WIDTH] : '0;
            mem_addr    = req_addr[int'(w_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wr_data = req_wdata[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock_port;
        w_rr_nxt    = r_rr_ptr;
        if (w_gnt_any) begin
            if (r_state == ARB_UNLOCKED) begin
                if (!req_last[w_gnt_idx] && (LOCK_BURST != 0)) begin
                    w_state_nxt = ARB_LOCKED;
                    w_lock_nxt  = w_gnt_idx;
                end else begin
                    w_rr_nxt = next_port(w_gnt_idx);
                end
            end else if (req_last[w_gnt_idx]) begin
                w_state_nxt = ARB_UNLOCKED;
                w_rr_nxt    = next_port(w_gnt_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_UNLOCKED;
            r_lock_port <= '0;
            r_rr_ptr    <= '0;
            r_inflight  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lock_port <= w_lock_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_inflight  <= w_grant & ~req_we;
        end
    end

    generate
        for (genvar p = 0; p < PORTS; p++) begin : g_resp
            assign w_pop[p] = resp_valid[p] & resp_ready[p];

            dmem_resp_skid #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_skid (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (r_inflight[p]),
                .push_data (mem_rd_data),
                .valid     (resp_valid[p]),
                .data      (resp_data[p*DATA_WIDTH +: DATA_WIDTH]),
                .ready     (resp_ready[p]),
                .count     (w_count[p])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Round-robin arbiter that shares the core's single DMEM DMA port (one access per cycle, 1-cycle read latency) between `PORTS` independent read/write requesters, such as the AXI write path, the AXI read path and a packet accelerator. It keeps bursts atomic on request, prevents any read from issuing unless its response has guaranteed buffer space, and returns each read response to the requester that issued it, in order, with valid/ready backpressure. It sits between the AXI RAM interface adapters and the memory port of `riscvcore`.

## Interface
Parameters:
- `PORTS`, 3: number of requesters, 2..8.
- `DATA_WIDTH`, 64: memory word width.
- `ADDR_WIDTH`, 16: word-byte address width, passed through unchanged.
- `STRB_WIDTH`, DATA_WIDTH/8: byte strobes.
- `LOCK_BURST`, 1: when 1, a granted port keeps the grant until its `last` beat; when 0, the grant rotates after every beat.

Ports (packed vectors, port p occupies slice p):
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: clock.
  - `rst_n` in 1: reset.
- Request channel:
  - `req_valid` in PORTS: request present.
  - `req_we` in PORTS: 1 = write, 0 = read.
  - `req_addr` in PORTS*ADDR_WIDTH: address.
  - `req_wdata` in PORTS*DATA_WIDTH: write data.
  - `req_strb` in PORTS*STRB_WIDTH: write strobes.
  - `req_last` in PORTS: last beat of burst.
  - `req_ready` out PORTS: beat accepted this cycle.
- Response channel:
  - `resp_valid` out PORTS: read data available.
  - `resp_data` out PORTS*DATA_WIDTH: read data.
  - `resp_ready` in PORTS: requester consumes the response.
- Memory port:
  - `mem_en` out 1: memory access enable.
  - `mem_ren` out 1: read access.
  - `mem_wen` out STRB_WIDTH: write strobes; all zero on a read.
  - `mem_addr` out ADDR_WIDTH: access address.
  - `mem_wr_data` out DATA_WIDTH: write data.
  - `mem_rd_data` in DATA_WIDTH: read data, valid 1 cycle after `mem_ren`.

## Operation
- **Eligibility.** Port p is eligible when `req_valid[p]` is 1 and one of these holds:
  - it is a write, or
  - it is a read and `credit_ok[p]` is true.
- **Read credit.** `credit_ok[p]` means `inflight[p] + count[p] − pop[p] < 2`, where:
  - `inflight[p]` is a read issued last cycle,
  - `count[p]` is the occupancy of the 2-entry response buffer,
  - `pop[p] = resp_valid[p] & resp_ready[p]`.
- **Grant selection.** At most one grant per cycle. Search starts at `rr_ptr` and proceeds upward modulo PORTS; the first eligible port wins.
- **State machine.** State `UNLOCKED`, or `LOCKED(lock_port)`.
  - `UNLOCKED`: round-robin grant.
    - Accepted beat with `last=0` and `LOCK_BURST=1` → `LOCKED(p)`.
    - Accepted beat with `last=1`, or any accepted beat when `LOCK_BURST=0` → `rr_ptr` ← p+1 mod PORTS.
  - `LOCKED(q)`: only q may be granted. If q is not eligible, the cycle is idle and no other port is served.
    - Accepted beat with `last=1` → `UNLOCKED` and `rr_ptr` ← q+1.
- **Grant outputs.**
  - `req_ready[p]` = grant[p], combinational from `req_valid` and state.
  - The `mem_*` outputs are driven combinationally from the granted request.
  - With no grant: `mem_en=0`, `mem_ren=0`, `mem_wen=0`.
- **Read path.**
  - A granted read sets `inflight[p]` for one cycle.
  - The next cycle, `mem_rd_data` is pushed into buffer p.
  - Each buffer is FIFO; order is preserved per port.
  - A port whose `req_valid` is 0 never holds the grant; a locked port stalls everyone (by design, so bursts are atomic).

## Timing
- **Reset values** (asynchronous, on `rst_n=0`):
  - `req_ready=0`, `resp_valid=0`, `mem_en=0`, `mem_ren=0`, `mem_wen=0`.
  - `mem_addr`/`mem_wr_data` = 0 when idle.
  - `rr_ptr=0`, state `UNLOCKED`, buffers and `inflight` cleared.
- **Reset mid-burst.** All in-flight reads and buffered data are discarded.
- **Write latency.** 0: the write reaches memory in the cycle it is accepted.
- **Read latency.** Issue in cycle t → `resp_valid` in cycle t+2 if the buffer was empty.
- **Throughput.** One beat per cycle aggregate. A single read port with `resp_ready` held at 1 sustains 1 read per cycle.
- **Buffer full.** `count=2` with no pop → reads from that port are ineligible; its writes are still eligible.
- **Simultaneous push and pop** on one buffer: count is unchanged.
- **Pointer wrap.** `rr_ptr` wraps from PORTS−1 to 0.

## Structure
- Shared package `dmem_arb_pkg`:
  - state encodings `ARB_UNLOCKED`/`ARB_LOCKED`,
  - `MEM_RD_LATENCY=1`,
  - `RESP_DEPTH=2`.
- Sub-module `dmem_resp_skid`: 2-entry FIFO with `count` output, instantiated once per port via generate.
- The round-robin priority search is a function in the top module.

## Test plan
- **Round-robin fairness.** `LOCK_BURST=0`, ports 0/1/2 all issue continuous single-beat writes to 0x0000/0x0100/0x0200 → grants cycle 0,1,2,0,…; each port gets exactly 1/3 of 30 cycles.
- **Burst lock.** `LOCK_BURST=1`:
  - Port 1 issues a 4-beat write burst to 0x0040; port 0 requests 1 read.
  - Expect: port 1 holds 4 consecutive cycles; port 0 is granted in cycle 5; `rr_ptr`=2 after.
- **Locked stall.** Port 2 drops `req_valid` mid-burst for 3 cycles while port 0 is waiting → `mem_en=0` for those 3 cycles; port 0 waits until port 2's `last` beat.
- **Backpressure.** Port 0 reads 0x10..0x18 with `resp_ready=0`:
  - Exactly 2 reads are accepted, then `req_ready[0]=0`.
  - Raise `resp_ready` → data returns in address order, with no loss and no duplication.
- **Simultaneous push and pop.** Memory returns pattern `A5A5_0000_0000_00nn`; `resp_ready=1` throughout → 1 read per cycle, each response exactly 2 cycles after issue.
- **Reset mid-operation.** Assert `rst_n=0` during a burst with 2 responses buffered → all outputs go to 0 immediately. After release, the first grant goes to the lowest eligible port from `rr_ptr=0`.
